my_test: RTL and testbench

MY_TEST -- requirements
Module: my_test

---
 rtl/my_test.sv | 73 +++++++
 tb/tb_my_test.sv | 114 +++++++++++
 2 files changed

// File: rtl/my_test.sv
// Free-running self-test sequence generator: FIB_LEN Fibonacci terms (mod 64),
// then one full period of a 6-bit maximal-length LFSR, then parks at zero.
module my_test #(
  parameter int FIB_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  output logic [5:0] ans
);

  localparam logic [1:0] S_FIB  = 2'd0;
  localparam logic [1:0] S_LFSR = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [5:0] FIB_LAST  = 6'(FIB_LEN - 1);
  localparam logic [5:0] LFSR_LAST = 6'd62;
  localparam logic [5:0] LFSR_SEED = 6'b000001;

  logic [1:0] state;
  logic [5:0] a;
  logic [5:0] b;
  logic [5:0] lfsr;
  logic [5:0] cnt;
  logic [5:0] lfsr_next;

  // x^6 + x^5 + 1: taps on bits 5 and 4, shifting toward the MSB
  assign lfsr_next = {lfsr[4:0], lfsr[5] ^ lfsr[4]};

  // NOTE: every register here is updated with <= so all right-hand sides see
  // the pre-edge values; that is what makes a <= b, b <= a + b a correct swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FIB;
      a     <= 6'd0;
      b     <= 6'd1;
      cnt   <= 6'd0;
      lfsr  <= LFSR_SEED;
      ans   <= 6'd0;
    end else begin
      case (state)
        S_FIB: begin
          a <= b;
          b <= a + b;
          if (cnt == FIB_LAST) begin
            state <= S_LFSR;
            lfsr  <= LFSR_SEED;
            cnt   <= 6'd0;
            ans   <= LFSR_SEED;
          end else begin
            cnt <= cnt + 6'd1;
            ans <= b;
          end
        end
        S_LFSR: begin
          if (cnt == LFSR_LAST) begin
            state <= S_DONE;
            ans   <= 6'd0;
          end else begin
            lfsr <= lfsr_next;
            ans  <= lfsr_next;
            cnt  <= cnt + 6'd1;
          end
        end
        default: begin
          // DONE (and the unused encoding) hold everything until reset
          state <= S_DONE;
          ans   <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_my_test.sv
// Directed bench for my_test: default build plus a FIB_LEN=4 build sharing clk/rst.
module tb_my_test;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] ans;
  logic [5:0] ans4;

  int checks = 0;
  int errors = 0;

  my_test #(.FIB_LEN(16)) dut (
    .clk(clk),
    .rst(rst),
    .ans(ans)
  );

  my_test #(.FIB_LEN(4)) dut4 (
    .clk(clk),
    .rst(rst),
    .ans(ans4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic got);
    checks++;
    if (got !== 1'b1) begin
      errors++;
      $display("FAIL %s: condition false (got %b expected 1)", tag, got);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [5:0] exp16 [1:22] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 25, 16, 41, 57, 34,
                               1, 2, 4, 8, 16, 33, 3};
  logic [5:0] exp4  [1:10] = '{1, 1, 2, 1, 2, 4, 8, 16, 33, 3};
  logic [5:0] run1  [1:79];
  bit         seen  [64];

  initial begin
    // Reset held for two edges
    rst = 1'b1;
    step();
    step();
    check("reset_ans", ans, 6'd0);
    check("reset_ans4", ans4, 6'd0);
    rst = 1'b0;

    foreach (seen[i]) seen[i] = 1'b0;
    for (int e = 1; e <= 79; e++) begin
      step();
      run1[e] = ans;
      if (e <= 22) check($sformatf("seq16_e%0d", e), ans, exp16[e]);
      if (e >= 16 && e <= 78) begin
        check_bit($sformatf("lfsr_nonzero_e%0d", e), ans != 6'd0);
        check_bit($sformatf("lfsr_unique_e%0d", e), !seen[ans]);
        seen[ans] = 1'b1;
      end
      if (e == 79) check("done16_e79", ans, 6'd0);
      if (e <= 10) check($sformatf("seq4_e%0d", e), ans4, exp4[e]);
      if (e == 66) check_bit("fib4_e66_nonzero", ans4 != 6'd0);
      if (e >= 67) check($sformatf("done4_e%0d", e), ans4, 6'd0);
    end

    for (int e = 0; e < 100; e++) step();
    check("done16_hold", ans, 6'd0);
    check("done4_hold", ans4, 6'd0);

    // Single-edge reset from DONE must replay the first run exactly
    rst = 1'b1;
    step();
    check("done_reset_ans", ans, 6'd0);
    rst = 1'b0;
    for (int e = 1; e <= 79; e++) begin
      step();
      check($sformatf("replay_e%0d", e), ans, run1[e]);
    end

    // Single-edge reset in the middle of the LFSR phase (edge 40)
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int e = 1; e <= 39; e++) step();
    check("pre_mid_e39", ans, run1[39]);
    rst = 1'b1;
    step();
    check("mid_reset_e40", ans, 6'd0);
    rst = 1'b0;
    step();
    check("mid_restart_f1", ans, 6'd1);
    step();
    check("mid_restart_f2", ans, 6'd1);
    step();
    check("mid_restart_f3", ans, 6'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
